// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI word sequencer.
package spi_seq_pkg;

  localparam int FRAME_W = 16;
  localparam int WORD_W  = 32;

  localparam logic [1:0] MODE_XCHG = 2'b00;
  localparam logic [1:0] MODE_TX   = 2'b01;
  localparam logic [1:0] MODE_RX   = 2'b10;
  localparam logic [1:0] MODE_CLR  = 2'b11;  // exchange that also clears the sticky timeout flag

  typedef enum logic [3:0] {
    IDLE,
    START_HI,
    WAIT_HI,
    GAP_HI,
    START_LO,
    WAIT_LO,
    GAP_LO,
    DONE,
    ABORT
  } state_t;

  // Every mode except rx-only launches the transmit side.
  function automatic logic mode_uses_tx(input logic [1:0] mode);
    return mode != MODE_TX ? (mode != MODE_RX) : 1'b1;
  endfunction

  // Every mode except tx-only launches the receive side.
  function automatic logic mode_uses_rx(input logic [1:0] mode);
    return mode != MODE_TX;
  endfunction

  // Rx-only frames shift out zeros.
  function automatic logic [FRAME_W-1:0] tx_frame(input logic [1:0] mode,
                                                   input logic [FRAME_W-1:0] half);
    return (mode == MODE_RX) ? '0 : half;
  endfunction

endpackage

// File: rtl/spi_seq_timer.sv
// Loadable saturating down-counter; shared by the gap and timeout phases.
module spi_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count_reg;

  // Load wins; otherwise count down and park at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/spi_word_sequencer.sv
// Splits a 32-bit word into two 16-bit SPI frames (high half first), enforces
// the inter-frame gap, aborts stalled frames and reassembles the reply.
module spi_word_sequencer
  import spi_seq_pkg::*;
#(
  parameter int GAP_CYCLES     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic [1:0]         in_mode,
  output logic               slave_tx_start,
  output logic               slave_rx_start,
  output logic [FRAME_W-1:0] input_reg_data,
  input  logic [FRAME_W-1:0] output_reg_data,
  input  logic               rx_valid,
  input  logic               tx_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic               busy,
  output logic               timeout_err
);

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int TMR_W = (TO_W > GAP_W) ? TO_W : GAP_W;

  // The timer reads zero on the last cycle of a phase, so load length-1.
  localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);

  state_t               state_reg;
  logic [1:0]           mode_reg;
  logic [FRAME_W-1:0]   lo_word_reg;
  logic [FRAME_W-1:0]   hi_frame_reg;
  logic [FRAME_W-1:0]   lo_frame_reg;
  logic                 in_ready_reg;
  logic                 busy_reg;
  logic                 tx_start_reg;
  logic                 rx_start_reg;
  logic [FRAME_W-1:0]   ird_reg;
  logic                 out_valid_reg;
  logic [WORD_W-1:0]    out_data_reg;
  logic                 timeout_err_reg;

  logic                 frame_done;
  logic                 timer_load;
  logic [TMR_W-1:0]     timer_value;
  logic                 timer_zero;

  assign frame_done = tx_done | rx_valid;

  // Reload the shared timer whenever a timed phase begins.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = GAP_LOAD;
    case (state_reg)
      START_HI, START_LO: begin
        timer_load  = 1'b1;
        timer_value = TO_LOAD;
      end
      WAIT_HI, WAIT_LO: begin
        if (frame_done || timer_zero) begin
          timer_load  = 1'b1;
          timer_value = GAP_LOAD;  // both the gap and the abort hold-off last GAP_CYCLES
        end
      end
      default: ;
    endcase
  end

  spi_seq_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  // Sequencer FSM; every output is a register updated on the transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      mode_reg        <= MODE_XCHG;
      lo_word_reg     <= '0;
      hi_frame_reg    <= '0;
      lo_frame_reg    <= '0;
      in_ready_reg    <= 1'b1;
      busy_reg        <= 1'b0;
      tx_start_reg    <= 1'b0;
      rx_start_reg    <= 1'b0;
      ird_reg         <= '0;
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      tx_start_reg <= 1'b0;
      rx_start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            mode_reg     <= in_mode;
            lo_word_reg  <= in_data[FRAME_W-1:0];
            ird_reg      <= tx_frame(in_mode, in_data[WORD_W-1:FRAME_W]);
            tx_start_reg <= mode_uses_tx(in_mode);
            rx_start_reg <= mode_uses_rx(in_mode);
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            if (in_mode == MODE_CLR) begin
              timeout_err_reg <= 1'b0;
            end
            state_reg <= START_HI;
          end
        end
        START_HI: state_reg <= WAIT_HI;
        WAIT_HI: begin
          // A done on the last timeout cycle still counts as done.
          if (frame_done) begin
            hi_frame_reg <= output_reg_data;
            state_reg    <= GAP_HI;
          end else if (timer_zero) begin
            timeout_err_reg <= 1'b1;
            state_reg       <= ABORT;
          end
        end
        GAP_HI: begin
          if (timer_zero) begin
            ird_reg      <= tx_frame(mode_reg, lo_word_reg);
            tx_start_reg <= mode_uses_tx(mode_reg);
            rx_start_reg <= mode_uses_rx(mode_reg);
            state_reg    <= START_LO;
          end
        end
        START_LO: state_reg <= WAIT_LO;
        WAIT_LO: begin
          if (frame_done) begin
            lo_frame_reg <= output_reg_data;
            state_reg    <= GAP_LO;
          end else if (timer_zero) begin
            timeout_err_reg <= 1'b1;
            state_reg       <= ABORT;
          end
        end
        GAP_LO: begin
          if (timer_zero) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= {hi_frame_reg, lo_frame_reg};
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        ABORT: begin
          if (timer_zero) begin
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: begin
          in_ready_reg <= 1'b1;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready       = in_ready_reg;
  assign busy           = busy_reg;
  assign slave_tx_start = tx_start_reg;
  assign slave_rx_start = rx_start_reg;
  assign input_reg_data = ird_reg;
  assign out_valid      = out_valid_reg;
  assign out_data       = out_data_reg;
  assign timeout_err    = timeout_err_reg;

endmodule

// File: tb/tb_spi_word_sequencer.sv
// Bench for spi_word_sequencer: a timeline model plans every cycle's stimulus
// and expected outputs up front, then the run replays and compares them.
module tb_spi_word_sequencer;

  localparam int G  = 64;
  localparam int T  = 32;
  localparam int NC = 16384;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, slave_tx_start, slave_rx_start;
  logic        rx_valid, tx_done, out_valid, out_ready, busy, timeout_err;
  logic [31:0] in_data, out_data;
  logic [1:0]  in_mode;
  logic [15:0] input_reg_data, output_reg_data;

  spi_word_sequencer #(.GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .slave_tx_start(slave_tx_start),
    .slave_rx_start(slave_rx_start), .input_reg_data(input_reg_data),
    .output_reg_data(output_reg_data), .rx_valid(rx_valid), .tx_done(tx_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // stimulus per cycle
  logic        d_reset[NC], d_valid[NC], d_txd[NC], d_rxv[NC], d_ordy[NC];
  logic [31:0] d_data[NC];
  logic [1:0]  d_mode[NC];
  logic [15:0] d_ord[NC];
  // expectations per cycle
  logic        e_chk[NC], e_tx[NC], e_rx[NC], e_ov[NC], e_ir[NC], e_busy[NC], e_terr[NC];
  logic        e_ird_chk[NC], e_od_chk[NC];
  logic [15:0] e_ird[NC];
  logic [31:0] e_od[NC];

  typedef struct { int c; int sel; logic [31:0] val; } lit_t;
  lit_t lits[$];

  int   t, t_end, cyc, checks, errors;
  bit   running;
  logic terr_m;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic clear_from(input int c0);
    for (int c = c0; c < NC; c++) begin
      d_reset[c] = 1'b0; d_valid[c] = 1'b0; d_txd[c] = 1'b0; d_rxv[c] = 1'b0;
      d_ordy[c] = 1'($urandom_range(0, 1));
      d_data[c] = $urandom; d_mode[c] = 2'($urandom_range(0, 3)); d_ord[c] = 16'($urandom);
      e_chk[c] = 1'b0; e_ird_chk[c] = 1'b0; e_od_chk[c] = 1'b0;
    end
  endtask

  task automatic set_idle(input int c);
    e_chk[c] = 1'b1; e_tx[c] = 1'b0; e_rx[c] = 1'b0; e_ov[c] = 1'b0;
    e_ir[c] = 1'b1; e_busy[c] = 1'b0; e_terr[c] = terr_m;
    e_ird_chk[c] = 1'b0; e_od_chk[c] = 1'b0;
  endtask

  task automatic set_busy(input int c);
    set_idle(c); e_ir[c] = 1'b0; e_busy[c] = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin set_idle(t); t++; end
  endtask

  task automatic pin(input int c, input int sel, input logic [31:0] val);
    lit_t l;
    l.c = c; l.sel = sel; l.val = val;
    lits.push_back(l);
  endtask

  // One frame launched in cycle s; the master answers d cycles later (0 = never).
  task automatic plan_frame(input int s, input logic [1:0] m, input logic [15:0] w,
                            input int d, input logic [15:0] resp, output int nxt, output bit ok);
    logic ux, ur;
    int   wl, pick;
    ux = (m != 2'b10);
    ur = (m != 2'b01);
    ok = (d >= 1 && d <= T);
    wl = ok ? d : T;
    for (int c = s; c <= s + wl; c++) begin
      set_busy(c);
      e_ird_chk[c] = 1'b1;
      e_ird[c] = (m == 2'b10) ? 16'h0000 : w;
    end
    e_tx[s] = ux;
    e_rx[s] = ur;
    if (ok) begin
      pick = (ux && ur) ? $urandom_range(0, 2) : 0;
      d_txd[s + d] = ux && (pick != 2);
      d_rxv[s + d] = ur && (pick != 1);
      d_ord[s + d] = resp;
      for (int c = s + d + 1; c <= s + d + G; c++) set_busy(c);
      if ($urandom_range(0, 2) == 0) d_txd[s + d + 1 + $urandom_range(0, G - 1)] = 1'b1;
      nxt = s + d + G + 1;
    end else begin
      terr_m = 1'b1;
      for (int c = s + T + 1; c <= s + T + G; c++) set_busy(c);
      nxt = s + T + G + 1;
    end
  endtask

  // A whole word offered in cycle t; bp = extra cycles out_ready stays low.
  task automatic plan_word(input logic [31:0] w, input logic [1:0] m, input int d1, input int d2,
                           input logic [15:0] rhi, input logic [15:0] rlo, input int bp,
                           output int s2, output int v);
    int n, t0;
    bit ok;
    t0 = t;
    s2 = -1;
    v  = -1;
    set_idle(t);
    d_valid[t] = 1'b1; d_data[t] = w; d_mode[t] = m;
    if (m == 2'b11) terr_m = 1'b0;
    plan_frame(t + 1, m, w[31:16], d1, rhi, n, ok);
    if (ok) begin
      s2 = n;
      plan_frame(n, m, w[15:0], d2, rlo, n, ok);
    end
    if (ok) begin
      v = n;
      for (int c = n; c <= n + bp; c++) begin
        set_busy(c);
        e_ov[c] = 1'b1; e_od_chk[c] = 1'b1; e_od[c] = {rhi, rlo};
        d_ordy[c] = (c == n + bp);
      end
      n = n + bp + 1;
    end
    for (int c = t0 + 1; c < n; c++) d_valid[c] = 1'($urandom_range(0, 1));
    t = n;
  endtask

  task automatic plan_reset(input int r, input int n);
    clear_from(r);
    terr_m = 1'b0;
    for (int c = r; c < r + n; c++) begin
      set_idle(c);
      d_reset[c] = 1'b1;
      e_ird_chk[c] = 1'b1; e_ird[c] = 16'h0;
      e_od_chk[c] = 1'b1;  e_od[c] = 32'h0;
    end
    d_valid[r + n - 1] = 1'b1;
    t = r + n;
  endtask

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      0: return out_data;
      1: return 32'(out_valid);
      2: return 32'(input_reg_data);
      3: return 32'(slave_tx_start);
      4: return 32'(slave_rx_start);
      5: return 32'(timeout_err);
      6: return 32'(in_ready);
      default: return 32'(busy);
    endcase
  endfunction

  function automatic string probe_name(input int sel);
    case (sel)
      0: return "pin_out_data";
      1: return "pin_out_valid";
      2: return "pin_input_reg_data";
      3: return "pin_tx_start";
      4: return "pin_rx_start";
      5: return "pin_timeout_err";
      6: return "pin_in_ready";
      default: return "pin_busy";
    endcase
  endfunction

  task automatic apply(input int c);
    reset = d_reset[c]; in_valid = d_valid[c]; in_data = d_data[c]; in_mode = d_mode[c];
    tx_done = d_txd[c]; rx_valid = d_rxv[c]; output_reg_data = d_ord[c]; out_ready = d_ordy[c];
  endtask

  // Per-cycle comparison of every output against the planned timeline.
  always @(negedge clk) begin
    if (running && e_chk[cyc]) begin
      chk("slave_tx_start", 32'(slave_tx_start), 32'(e_tx[cyc]));
      chk("slave_rx_start", 32'(slave_rx_start), 32'(e_rx[cyc]));
      chk("out_valid", 32'(out_valid), 32'(e_ov[cyc]));
      chk("in_ready", 32'(in_ready), 32'(e_ir[cyc]));
      chk("busy", 32'(busy), 32'(e_busy[cyc]));
      chk("timeout_err", 32'(timeout_err), 32'(e_terr[cyc]));
      if (e_ird_chk[cyc]) chk("input_reg_data", 32'(input_reg_data), 32'(e_ird[cyc]));
      if (e_od_chk[cyc]) chk("out_data", out_data, e_od[cyc]);
    end
  end

  initial begin
    int t0, s2, v, d1, d2, bp;
    logic [1:0] m;
    checks = 0; errors = 0; running = 1'b0; cyc = 0;
    terr_m = 1'b0; t = 0;
    clear_from(0);
    plan_reset(0, 3);
    idle(2);

    // single exchange with known replies
    t0 = t;
    plan_word(32'hDEAD_BEEF, 2'b00, 10, 10, 16'h1234, 16'h5678, 0, s2, v);
    chk("model_latency", 32'(v - t0), 32'd151);
    chk("model_out_data", e_od[v], 32'h1234_5678);
    pin(t0 + 1, 2, 32'h0000_DEAD); pin(t0 + 1, 3, 1); pin(t0 + 1, 4, 1);
    pin(s2, 2, 32'h0000_BEEF);
    pin(v, 0, 32'h1234_5678); pin(v, 1, 1);
    idle(3);

    // backpressure: 100 cycles of out_ready low
    plan_word($urandom, 2'b00, 7, 12, 16'($urandom), 16'($urandom), 100, s2, v);
    idle(1);

    // timeout: master stays silent
    t0 = t;
    plan_word(32'hCAFE_0001, 2'b00, 0, 5, 16'h1111, 16'h2222, 0, s2, v);
    chk("model_abort_len", 32'(t - t0), 32'(T + G + 2));
    pin(t0 + T + 2, 5, 1); pin(t0 + T + 2, 6, 0); pin(t0 + T + G + 2, 6, 1);
    idle(2);
    t0 = t;
    plan_word(32'h0BAD_F00D, 2'b11, 4, 4, 16'hAAAA, 16'h5555, 0, s2, v);
    pin(t0 + 1, 5, 0);
    idle(2);

    // tx-only then rx-only
    t0 = t;
    plan_word(32'h0001_0002, 2'b01, 6, 9, 16'h00F0, 16'h0F00, 1, s2, v);
    pin(t0 + 1, 3, 1); pin(t0 + 1, 4, 0); pin(t0 + 1, 2, 32'h0000_0001); pin(s2, 2, 32'h0000_0002);
    idle(1);
    t0 = t;
    plan_word(32'h7777_8888, 2'b10, 3, 20, 16'hABCD, 16'hEF01, 0, s2, v);
    pin(t0 + 1, 3, 0); pin(t0 + 1, 4, 1); pin(t0 + 1, 2, 0);
    idle(1);

    // done on the very last timeout cycle of both frames
    plan_word(32'h1357_9BDF, 2'b00, T, T, 16'h2468, 16'hACE0, 0, s2, v);
    pin(v, 0, 32'h2468_ACE0); pin(v, 5, 0);
    idle(1);

    // reset in the middle of WAIT_LO, then a fresh word
    plan_word(32'hFEED_FACE, 2'b00, 5, 30, 16'h0101, 16'h0202, 0, s2, v);
    plan_reset(s2 + 10, 2);
    plan_word(32'h0F0F_F0F0, 2'b00, 8, 8, 16'h3333, 16'h4444, 0, s2, v);
    idle(2);

    // randomized traffic
    for (int k = 0; k < 25 && t < NC - 600; k++) begin
      m  = 2'($urandom_range(0, 3));
      d1 = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, T));
      d2 = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, T));
      bp = int'($urandom_range(0, 5));
      plan_word($urandom, m, d1, d2, 16'($urandom), 16'($urandom), bp, s2, v);
      idle(int'($urandom_range(0, 3)));
    end
    idle(3);
    t_end = t;

    // replay
    apply(0);
    running = 1'b1;
    while (cyc < t_end) begin
      @(posedge clk);
      #1;
      cyc++;
      apply(cyc);
      foreach (lits[i]) begin
        if (lits[i].c == cyc) chk(probe_name(lits[i].sel), probe(lits[i].sel), lits[i].val);
      end
    end
    @(negedge clk);
    #1;
    running = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
